// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM channel link (transmit mux and slot counter).
package tdm_pkg;

  localparam int TDM_N = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tdm_state_e;

  // Select width for a given channel count; a single channel still needs one bit.
  function automatic int tdm_selw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-N slot counter with load-zero, enable and terminal-count output.
// Wraps at N-1 so select codes >= N are never produced.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int N = TDM_N,
  localparam int W = tdm_selw(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load_zero,
  input  logic         i_enable,
  output logic [W-1:0] o_count,
  output logic         o_terminal
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_count;
  logic         w_terminal;

  assign w_terminal = (r_count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load_zero) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_terminal ? '0 : r_count + 1'b1;
    end
  end

  assign o_count    = r_count;
  assign o_terminal = w_terminal;

endmodule

// File: rtl/tdm_mux.sv
// Time-division multiplexer: accepts an N-bit word via valid/ready and
// serialises it as one (d, sel) slot per cycle, with downstream stall.
module tdm_mux
  import tdm_pkg::*;
#(
  parameter int N = TDM_N,
  localparam int SELW = tdm_selw(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_data,
  input  logic            out_ready,
  output logic            out_valid,
  output logic            d,
  output logic [SELW-1:0] sel,
  output logic            frame_start
);

  tdm_state_e r_state;
  tdm_state_e r_state_next;

  logic [N-1:0]    r_shift;
  logic [N-1:0]    r_shift_next;
  logic            r_d;
  logic            r_d_next;
  logic            r_valid;
  logic            r_valid_next;
  logic            r_fs;
  logic            r_fs_next;

  logic            w_advance;
  logic            w_xfer;
  logic            w_tc;
  logic [SELW-1:0] w_count;

  // A slot is consumed only while presenting one and downstream accepts it.
  assign w_advance = (r_state == SEND) && out_ready;
  assign in_ready  = (r_state == IDLE) || (w_advance && w_tc);
  assign w_xfer    = in_valid && in_ready;

  tdm_slot_counter #(
    .N (N)
  ) u_slot_counter (
    .clk         (clk),
    .reset       (reset),
    .i_load_zero (w_xfer || (w_advance && w_tc)),
    .i_enable    (w_advance),
    .o_count     (w_count),
    .o_terminal  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= r_state_next;
    end
  end

  always_comb begin
    r_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          r_state_next = SEND;
        end
      end
      SEND: begin
        if (w_advance && w_tc) begin
          r_state_next = w_xfer ? SEND : IDLE;
        end
      end
      default: r_state_next = IDLE;
    endcase
  end

  // The shift register always holds the not-yet-presented bits with the
  // next slot's bit at position 0.
  always_comb begin
    r_shift_next = r_shift;
    r_d_next     = r_d;
    r_valid_next = r_valid;
    r_fs_next    = r_fs;
    if (w_xfer) begin
      r_shift_next = in_data >> 1;
      r_d_next     = in_data[0];
      r_valid_next = 1'b1;
      r_fs_next    = 1'b1;
    end else if (w_advance) begin
      r_fs_next = 1'b0;
      if (w_tc) begin
        r_d_next     = 1'b0;
        r_valid_next = 1'b0;
      end else begin
        r_shift_next = r_shift >> 1;
        r_d_next     = r_shift[0];
        r_valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_d     <= 1'b0;
      r_valid <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_shift <= r_shift_next;
      r_d     <= r_d_next;
      r_valid <= r_valid_next;
      r_fs    <= r_fs_next;
    end
  end

  assign out_valid   = r_valid;
  assign d           = r_d;
  assign sel         = w_count;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_tdm_mux.sv
// Self-checking bench for tdm_mux: directed scenarios plus random traffic
// compared cycle by cycle against a word/slot reference model.
module tb_tdm_mux;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         out_ready = 1'b1;
  logic         out_valid;
  logic         d;
  logic [2:0]   sel;
  logic         frame_start;
  logic [N-1:0] y;

  int checks = 0;
  int errors = 0;

  // Reference model: is a word in flight, which one, and which slot is shown.
  logic         m_busy = 1'b0;
  logic [N-1:0] m_word = '0;
  int           m_slot = 0;

  tdm_mux #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .d           (d),
    .sel         (sel),
    .frame_start (frame_start)
  );

  // Receive-side demux: each slot's bit lands on its own output line.
  assign y = out_valid ? (N'(d) << sel) : '0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic iv, input logic [N-1:0] data,
                      input logic ordy, output logic xfer);
    logic exp_ready;
    logic [N-1:0] exp_y;
    @(negedge clk);
    reset     = rst;
    in_valid  = iv;
    in_data   = data;
    out_ready = ordy;
    #1;
    exp_ready = !m_busy || (m_slot == N - 1 && ordy);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    @(posedge clk);
    xfer = !rst && iv && exp_ready;
    if (rst) begin
      m_busy = 1'b0;
      m_slot = 0;
    end else if (xfer) begin
      m_busy = 1'b1;
      m_word = data;
      m_slot = 0;
    end else if (m_busy && ordy) begin
      if (m_slot == N - 1) begin
        m_busy = 1'b0;
        m_slot = 0;
      end else begin
        m_slot++;
      end
    end
    #1;
    exp_y = m_busy ? (N'(m_word[m_slot]) << m_slot) : '0;
    check("out_valid", 32'(out_valid), 32'(m_busy));
    check("sel", 32'(sel), m_busy ? 32'(m_slot) : 32'd0);
    check("d", 32'(d), m_busy ? 32'(m_word[m_slot]) : 32'd0);
    check("frame_start", 32'(frame_start), 32'(m_busy && m_slot == 0));
    check("demux_y", 32'(y), 32'(exp_y));
    $display("t=%0t rst=%0b iv=%0b data=%02h ordy=%0b xfer=%0b | ov=%0b sel=%0d d=%0b fs=%0b y=%02h",
             $time, rst, iv, data, ordy, xfer, out_valid, sel, d, frame_start, y);
  endtask

  initial begin
    logic x;
    int   acc;
    int   vcnt;
    int   guard;
    logic [N-1:0] w;

    // Reset state.
    step(1'b1, 1'b0, '0, 1'b1, x);
    step(1'b1, 1'b1, 8'h5A, 1'b1, x);
    step(1'b0, 1'b0, '0, 1'b1, x);

    // Single word 1010_0110, then drain back to idle.
    step(1'b0, 1'b1, 8'b1010_0110, 1'b1, x);
    check("accept_a6", 32'(x), 32'd1);
    for (int i = 0; i < N + 2; i++) step(1'b0, 1'b0, 8'hC3, 1'b1, x);

    // Back-to-back FF then 00 with in_valid held high.
    acc  = 0;
    vcnt = 0;
    guard = 0;
    while (acc < 2 && guard < 40) begin
      step(1'b0, 1'b1, (acc == 0) ? 8'hFF : 8'h00, 1'b1, x);
      if (x) acc++;
      if (out_valid) vcnt++;
      guard++;
    end
    check("b2b_accepts", 32'(acc), 32'd2);
    for (int i = 0; i < N; i++) begin
      step(1'b0, 1'b0, 8'hFF, 1'b1, x);
      if (out_valid) vcnt++;
    end
    check("b2b_valid_slots", 32'(vcnt), 32'd16);

    // Word 0x81 with a 3-cycle stall at slot 3.
    step(1'b0, 1'b1, 8'h81, 1'b1, x);
    vcnt = out_valid ? 1 : 0;
    guard = 0;
    while (sel != 3'd3 && guard < 20) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, x);
      if (out_valid) vcnt++;
      guard++;
    end
    check("reach_slot3", 32'(sel), 32'd3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, x);
      if (out_valid) vcnt++;
    end
    for (int i = 0; i < N; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, x);
      if (out_valid) vcnt++;
    end
    check("stall_frame_len", 32'(vcnt), 32'd11);

    // Reset mid-frame at slot 4, then a clean restart.
    step(1'b0, 1'b1, 8'hF7, 1'b1, x);
    guard = 0;
    while (sel != 3'd4 && guard < 20) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, x);
      guard++;
    end
    check("reach_slot4", 32'(sel), 32'd4);
    step(1'b1, 1'b1, 8'h3C, 1'b1, x);
    step(1'b0, 1'b1, 8'h6D, 1'b1, x);
    check("accept_after_reset", 32'(x), 32'd1);
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, 8'h00, 1'b1, x);

    // in_data churns every cycle; the captured word must be the one sent.
    step(1'b0, 1'b1, 8'($urandom), 1'b1, x);
    for (int i = 0; i < N + 1; i++) step(1'b0, 1'b0, 8'($urandom), 1'b1, x);

    // One-hot word into the demux.
    step(1'b0, 1'b1, 8'h10, 1'b1, x);
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, 8'h00, 1'b1, x);

    // Random traffic with stalls and occasional resets.
    for (int i = 0; i < 400; i++) begin
      w = 8'($urandom);
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), w,
           ($urandom_range(0, 3) != 0), x);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
